// File: rtl/key_debounce_sync.sv
// key_debounce_sync: two-flop synchroniser plus per-channel debounce for active-low keys,
// with registered one-cycle press/release strobes aligned to the key_out change.
module key_debounce_sync #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);
  typedef enum logic {STABLE, PENDING} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [NUM_KEYS-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 stable, stable_nxt, done, pp, rp;
    // PENDING persists only while the synchronised level disagrees with the accepted one
    always_comb begin
      state      = (sync2[i] == stable) ? STABLE : PENDING;
      done       = (state == PENDING) && (cnt == LAST);
      cnt_nxt    = (state == STABLE || done) ? '0 : cnt + 1'b1;
      stable_nxt = done ? sync2[i] : stable;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        stable <= 1'b1;
        pp     <= 1'b0;
        rp     <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        stable <= stable_nxt;
        pp     <= done & ~sync2[i];
        rp     <= done & sync2[i];
      end
    end
    assign key_out[i]       = stable;
    assign press_pulse[i]   = pp;
    assign release_pulse[i] = rp;
  end
endmodule

// File: tb/tb_key_debounce_sync.sv
// tb_key_debounce_sync: directed stimulus with a scoreboard of expected key_out edges.
module tb_key_debounce_sync;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_raw = 4'b0000;
  logic [3:0] key_out, press_pulse, release_pulse;
  typedef struct {int cyc; int ch; bit press;} ev_t;
  ev_t        sb[$];
  ev_t        ev;
  int         edges = 0, checks = 0, errors = 0;
  bit         rst_at_edge;
  logic [3:0] exp_ko = 4'b1111, exp_pp, exp_rp;
  always #5 clk = ~clk;
  key_debounce_sync #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw),
    .key_out(key_out), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );
  always @(posedge clk) begin
    edges++;
    rst_at_edge = reset;
  end
  // A raw change driven after edge E must show up on key_out at edge E+10
  always @(negedge clk) if (edges > 0) begin
    exp_pp = 4'b0000;
    exp_rp = 4'b0000;
    if (rst_at_edge) exp_ko = 4'b1111;
    else while (sb.size() > 0 && sb[0].cyc <= edges) begin
      ev = sb.pop_front();
      if (ev.press) begin
        exp_pp[ev.ch] = 1'b1;
        exp_ko[ev.ch] = 1'b0;
      end else begin
        exp_rp[ev.ch] = 1'b1;
        exp_ko[ev.ch] = 1'b1;
      end
    end
    checks += 3;
    assert (key_out === exp_ko) else begin
      errors++;
      $error("FAIL key_out edge %0d got %b exp %b", edges, key_out, exp_ko);
    end
    assert (press_pulse === exp_pp) else begin
      errors++;
      $error("FAIL press_pulse edge %0d got %b exp %b", edges, press_pulse, exp_pp);
    end
    assert (release_pulse === exp_rp) else begin
      errors++;
      $error("FAIL release_pulse edge %0d got %b exp %b", edges, release_pulse, exp_rp);
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input int ch, input bit press);
    sb.push_back('{edges + 10, ch, press});
  endtask
  initial begin
    step(3);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) expect_ev(c, 1'b1);
    step(14);
    key_raw = 4'b1111;
    for (int c = 0; c < 4; c++) expect_ev(c, 1'b0);
    step(14);
    key_raw[0] = 1'b0;
    expect_ev(0, 1'b1);
    step(15);
    key_raw[0] = 1'b1;
    expect_ev(0, 1'b0);
    step(15);
    for (int k = 0; k < 14; k++) begin
      key_raw[0] = k[0];
      step(3);
    end
    key_raw[0] = 1'b0;
    expect_ev(0, 1'b1);
    step(15);
    key_raw[2] = 1'b0;
    step(7);
    key_raw[2] = 1'b1;
    step(12);
    key_raw[2] = 1'b0;
    expect_ev(2, 1'b1);
    step(15);
    key_raw[2] = 1'b1;
    expect_ev(2, 1'b0);
    step(15);
    key_raw = 4'b0101;
    expect_ev(0, 1'b0);
    expect_ev(1, 1'b1);
    expect_ev(3, 1'b1);
    step(15);
    key_raw = 4'b1111;
    expect_ev(1, 1'b0);
    expect_ev(3, 1'b0);
    step(15);
    key_raw[1] = 1'b0;
    step(6);
    reset = 1'b1;
    sb.delete();
    step(1);
    reset = 1'b0;
    expect_ev(1, 1'b1);
    step(15);
    key_raw[1] = 1'b1;
    expect_ev(1, 1'b0);
    step(15);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
